// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control slice: opcode/funct
// constants, the FSM state encoding, datapath select encodings and the
// one-hot instruction class produced by the decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   // Field widths shared with the interface
   localparam int STATE_W = 3;
   localparam int ALU_W   = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_JAL  = 2'b10;
   localparam logic [1:0] NPC_REG  = 2'b11;

   localparam logic [1:0] WR_RT    = 2'b00;
   localparam logic [1:0] WR_RD    = 2'b01;
   localparam logic [1:0] WR_RA    = 2'b10;

   localparam logic [1:0] WD_ALU   = 2'b00;
   localparam logic [1:0] WD_DM    = 2'b01;
   localparam logic [1:0] WD_PC4   = 2'b10;

   // Exactly one bit is set for any opcode/funct pair
   typedef struct packed {
      logic rtypeAlu;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic jal;
      logic jr;
      logic illegal;
   } instrClass_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Bundle between the control FSM and the datapath.
//   master : control side (reads IR fields/zero/dmReady, drives enables/selects)
//   slave  : datapath side
// Signals: opcode, funct, zero, dmReady | pcWe, irWe, npcSel, rfWe, wrSel,
//          wdSel, bSel, extOp, aluOp, dmReq, dmWe, retire, busErr, state,
//          instrCnt
// -----------------------------------------------------------------------------
interface mc_ctrl_if #(parameter int CNT_W = 32);
   import mc_ctrl_pkg::*;

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               dmReady;
   logic               pcWe;
   logic               irWe;
   logic [1:0]         npcSel;
   logic               rfWe;
   logic [1:0]         wrSel;
   logic [1:0]         wdSel;
   logic               bSel;
   logic [1:0]         extOp;
   logic [ALU_W-1:0]   aluOp;
   logic               dmReq;
   logic               dmWe;
   logic               retire;
   logic               busErr;
   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   instrCnt;

   modport master (
      input  opcode, funct, zero, dmReady,
      output pcWe, irWe, npcSel, rfWe, wrSel, wdSel, bSel, extOp, aluOp,
             dmReq, dmWe, retire, busErr, state, instrCnt
   );

   modport slave (
      output opcode, funct, zero, dmReady,
      input  pcWe, irWe, npcSel, rfWe, wrSel, wdSel, bSel, extOp, aluOp,
             dmReq, dmWe, retire, busErr, state, instrCnt
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational classifier: IR opcode/funct -> one-hot instruction class.
//   opcode : IR[31:26]
//   funct  : IR[5:0]
//   cls    : one-hot class, illegal set for every unsupported encoding
// -----------------------------------------------------------------------------
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output instrClass_t cls
);

   // Anything not listed, including nop (all-zero R-type), lands in illegal
   // so the FSM can retire it as a two-cycle no-op.
   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU: cls.rtypeAlu = 1'b1;
               FN_JR:            cls.jr       = 1'b1;
               default:          cls.illegal  = 1'b1;
            endcase
         end
         OP_ORI:  cls.ori     = 1'b1;
         OP_LUI:  cls.lui     = 1'b1;
         OP_LW:   cls.lw      = 1'b1;
         OP_SW:   cls.sw      = 1'b1;
         OP_BEQ:  cls.beq     = 1'b1;
         OP_JAL:  cls.jal     = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle control FSM for the shared MIPS datapath
// (FETCH/DECODE/EXEC/MEM/WB) with DM ready handshake and timeout,
// retire pulse, sticky bus error and retired-instruction counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mc_ctrl_if.master (IR fields, zero, dmReady in; enables,
//           selects, retire, busErr, state, instrCnt out)
// -----------------------------------------------------------------------------
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input  logic     clk,
   input  logic     reset,
   mc_ctrl_if.master bus
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] waitCnt;
   logic [CNT_W-1:0]  instrCnt;
   logic              busErr;
   instrClass_t       cls;

   logic             pcWe, irWe, rfWe, bSel, dmReq, dmWe, retire;
   logic [1:0]       npcSel, wrSel, wdSel, extOp;
   logic [ALU_W-1:0] aluOp;

   mc_ctrl_decode uDecode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .cls    (cls)
   );

   // Output decode. Everything is a function of the current state and the
   // live IR/zero/dmReady inputs. The EXEC selects are kept active in MEM and
   // WB so the address and ALU result stay stable while they are consumed.
   // Reset forces every enable and select to zero regardless of state.
   always_comb begin
      pcWe   = 1'b0;
      irWe   = 1'b0;
      rfWe   = 1'b0;
      bSel   = 1'b0;
      dmReq  = 1'b0;
      dmWe   = 1'b0;
      retire = 1'b0;
      npcSel = NPC_PC4;
      wrSel  = WR_RT;
      wdSel  = WD_ALU;
      extOp  = EXT_ZERO;
      aluOp  = ALU_ADD;
      if (!reset) begin
         if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
            if (cls.rtypeAlu) aluOp = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            if (cls.ori) begin
               aluOp = ALU_OR;
               bSel  = 1'b1;
               extOp = EXT_ZERO;
            end
            if (cls.lui) begin
               aluOp = ALU_OR;
               bSel  = 1'b1;
               extOp = EXT_LUI;
            end
            if (cls.lw || cls.sw) begin
               aluOp = ALU_ADD;
               bSel  = 1'b1;
               extOp = EXT_SIGN;
            end
            if (cls.beq) aluOp = ALU_SUB;
         end
         case (state)
            ST_FETCH: begin
               irWe = 1'b1;
               pcWe = 1'b1;
            end
            ST_DECODE: retire = cls.illegal;
            ST_EXEC: begin
               if (cls.beq) begin
                  npcSel = NPC_BR;
                  pcWe   = bus.zero;
                  retire = 1'b1;
               end
               if (cls.jal) begin
                  npcSel = NPC_JAL;
                  pcWe   = 1'b1;
                  rfWe   = 1'b1;
                  wrSel  = WR_RA;
                  wdSel  = WD_PC4;
                  retire = 1'b1;
               end
               if (cls.jr) begin
                  npcSel = NPC_REG;
                  pcWe   = 1'b1;
                  retire = 1'b1;
               end
            end
            ST_MEM: begin
               dmReq  = 1'b1;
               dmWe   = cls.sw;
               retire = cls.sw && bus.dmReady;
            end
            ST_WB: begin
               rfWe   = 1'b1;
               retire = 1'b1;
               wrSel  = cls.rtypeAlu ? WR_RD : WR_RT;
               wdSel  = cls.lw ? WD_DM : WD_ALU;
            end
            default: ;
         endcase
      end
   end

   // State register plus the MEM wait counter, sticky bus error and retire
   // counter. A timeout abort returns to FETCH without retiring; a dmReady on
   // the last allowed cycle still counts as success because it is tested
   // first. waitCnt is cleared on every way out of MEM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_FETCH;
         waitCnt  <= '0;
         instrCnt <= '0;
         busErr   <= 1'b0;
      end else begin
         if (retire) instrCnt <= instrCnt + CNT_W'(1);
         case (state)
            ST_FETCH:  state <= ST_DECODE;
            ST_DECODE: state <= cls.illegal ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
               if (cls.rtypeAlu || cls.ori || cls.lui) state <= ST_WB;
               else if (cls.lw || cls.sw)              state <= ST_MEM;
               else                                    state <= ST_FETCH;
            end
            ST_MEM: begin
               if (bus.dmReady) begin
                  waitCnt <= '0;
                  state   <= cls.lw ? ST_WB : ST_FETCH;
               end else if (waitCnt == WAIT_LAST) begin
                  waitCnt <= '0;
                  busErr  <= 1'b1;
                  state   <= ST_FETCH;
               end else begin
                  waitCnt <= waitCnt + WAIT_W'(1);
               end
            end
            ST_WB:   state <= ST_FETCH;
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign bus.pcWe     = pcWe;
   assign bus.irWe     = irWe;
   assign bus.npcSel   = npcSel;
   assign bus.rfWe     = rfWe;
   assign bus.wrSel    = wrSel;
   assign bus.wdSel    = wdSel;
   assign bus.bSel     = bSel;
   assign bus.extOp    = extOp;
   assign bus.aluOp    = aluOp;
   assign bus.dmReq    = dmReq;
   assign bus.dmWe     = dmWe;
   assign bus.retire   = retire;
   assign bus.busErr   = busErr;
   assign bus.state    = state;
   assign bus.instrCnt = instrCnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Directed self-checking bench for mc_ctrl (MEM_TIMEOUT=16, CNT_W=32).
// -----------------------------------------------------------------------------
module tb_mc_ctrl;
   import mc_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   cmpCnt  = 0;
   int   failCnt = 0;
   int   expCnt  = 0;

   mc_ctrl_if #(.CNT_W(32)) bus ();

   mc_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.dmReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmpCnt++;
      if (bus.state !== 3'd0) begin failCnt++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
      cmpCnt++;
      if ({bus.pcWe, bus.irWe, bus.rfWe, bus.dmReq, bus.dmWe, bus.retire} !== 6'b0) begin
         failCnt++; $display("[TB] FAIL reset_enables: got %b expected 000000",
                             {bus.pcWe, bus.irWe, bus.rfWe, bus.dmReq, bus.dmWe, bus.retire});
      end
      cmpCnt++;
      if ({bus.npcSel, bus.wrSel, bus.wdSel, bus.bSel, bus.extOp, bus.aluOp} !== 12'b0) begin
         failCnt++; $display("[TB] FAIL reset_selects: got %b expected 0",
                             {bus.npcSel, bus.wrSel, bus.wdSel, bus.bSel, bus.extOp, bus.aluOp});
      end
      cmpCnt++;
      if (bus.instrCnt !== 32'd0 || bus.busErr !== 1'b0) begin
         failCnt++; $display("[TB] FAIL reset_counters: got cnt=%0d err=%b expected 0/0", bus.instrCnt, bus.busErr);
      end
      reset = 1'b0;
      #1;
      cmpCnt++;
      if (bus.irWe !== 1'b1 || bus.pcWe !== 1'b1) begin
         failCnt++; $display("[TB] FAIL fetch_enables: got ir=%b pc=%b expected 1/1", bus.irWe, bus.pcWe);
      end
   endtask

   task automatic test_addu;
      logic [2:0] expSt [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
      bus.opcode = 6'h00; bus.funct = 6'h21;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmpCnt++;
         if (bus.state !== expSt[i]) begin failCnt++; $display("[TB] FAIL addu_state[%0d]: got %0d expected %0d", i, bus.state, expSt[i]); end
         cmpCnt++;
         if (bus.rfWe !== (i == 3) || bus.retire !== (i == 3)) begin
            failCnt++; $display("[TB] FAIL addu_we[%0d]: got rf=%b ret=%b expected %b", i, bus.rfWe, bus.retire, (i == 3));
         end
         if (i == 2) begin
            cmpCnt++;
            if (bus.aluOp !== 3'b000 || bus.bSel !== 1'b0) begin
               failCnt++; $display("[TB] FAIL addu_exec: got alu=%b b=%b expected 000/0", bus.aluOp, bus.bSel);
            end
         end
         if (i == 3) begin
            cmpCnt++;
            if (bus.wrSel !== 2'b01 || bus.wdSel !== 2'b00) begin
               failCnt++; $display("[TB] FAIL addu_wb: got wr=%b wd=%b expected 01/00", bus.wrSel, bus.wdSel);
            end
         end
         tick();
      end
      expCnt++;
      cmpCnt++;
      if (bus.instrCnt !== 32'(expCnt) || bus.state !== 3'd0) begin
         failCnt++; $display("[TB] FAIL addu_done: got cnt=%0d st=%0d expected %0d/0", bus.instrCnt, bus.state, expCnt);
      end
      // subu only differs in the ALU op: check EXEC for 001
      bus.funct = 6'h23;
      tick(); tick();
      cmpCnt++;
      if (bus.state !== 3'd2 || bus.aluOp !== 3'b001) begin
         failCnt++; $display("[TB] FAIL subu_exec: got st=%0d alu=%b expected 2/001", bus.state, bus.aluOp);
      end
      tick(); tick();
      expCnt++;
   endtask

   task automatic test_imm;
      logic [5:0] ops  [2] = '{6'h0d, 6'h0f};
      logic [1:0] exts [2] = '{2'b00, 2'b10};
      for (int k = 0; k < 2; k++) begin
         bus.opcode = ops[k]; bus.funct = 6'h00;
         tick(); tick();
         cmpCnt++;
         if (bus.state !== 3'd2 || bus.extOp !== exts[k] || bus.bSel !== 1'b1 || bus.aluOp !== 3'b010) begin
            failCnt++; $display("[TB] FAIL imm_exec[%0d]: got st=%0d ext=%b b=%b alu=%b expected 2/%b/1/010",
                                k, bus.state, bus.extOp, bus.bSel, bus.aluOp, exts[k]);
         end
         tick();
         cmpCnt++;
         if (bus.state !== 3'd4 || bus.rfWe !== 1'b1 || bus.wrSel !== 2'b00 || bus.wdSel !== 2'b00 || bus.extOp !== exts[k]) begin
            failCnt++; $display("[TB] FAIL imm_wb[%0d]: got st=%0d rf=%b wr=%b wd=%b ext=%b expected 4/1/00/00/%b",
                                k, bus.state, bus.rfWe, bus.wrSel, bus.wdSel, bus.extOp, exts[k]);
         end
         tick();
         expCnt++;
      end
   endtask

   task automatic test_lw;
      logic [2:0] expSt [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      int reqs = 0;
      int rets = 0;
      bus.opcode = 6'h23; bus.dmReady = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.dmReady = (i == 6);
         #1;
         cmpCnt++;
         if (bus.state !== expSt[i]) begin failCnt++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, bus.state, expSt[i]); end
         if (bus.dmReq === 1'b1) reqs++;
         if (bus.retire === 1'b1) rets++;
         if (i == 3) begin
            cmpCnt++;
            if (bus.extOp !== 2'b01 || bus.bSel !== 1'b1 || bus.dmWe !== 1'b0) begin
               failCnt++; $display("[TB] FAIL lw_mem: got ext=%b b=%b we=%b expected 01/1/0", bus.extOp, bus.bSel, bus.dmWe);
            end
         end
         if (i == 7) begin
            cmpCnt++;
            if (bus.wdSel !== 2'b01 || bus.wrSel !== 2'b00 || bus.rfWe !== 1'b1) begin
               failCnt++; $display("[TB] FAIL lw_wb: got wd=%b wr=%b rf=%b expected 01/00/1", bus.wdSel, bus.wrSel, bus.rfWe);
            end
         end
         tick();
      end
      bus.dmReady = 1'b0;
      expCnt++;
      cmpCnt++;
      if (reqs !== 4 || rets !== 1) begin
         failCnt++; $display("[TB] FAIL lw_counts: got req=%0d ret=%0d expected 4/1", reqs, rets);
      end
      cmpCnt++;
      if (bus.state !== 3'd0 || bus.instrCnt !== 32'(expCnt)) begin
         failCnt++; $display("[TB] FAIL lw_done: got st=%0d cnt=%0d expected 0/%0d", bus.state, bus.instrCnt, expCnt);
      end
   endtask

   task automatic test_sw;
      // dmReady held high the whole time: only the MEM cycle may react to it
      bus.opcode = 6'h2b; bus.dmReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         cmpCnt++;
         if (bus.state !== 3'(i) || bus.retire !== (i == 3) || bus.dmReq !== (i == 3) || bus.dmWe !== (i == 3)) begin
            failCnt++; $display("[TB] FAIL sw_cycle[%0d]: got st=%0d ret=%b req=%b we=%b expected %0d/%b",
                                i, bus.state, bus.retire, bus.dmReq, bus.dmWe, i, (i == 3));
         end
         tick();
      end
      bus.dmReady = 1'b0;
      expCnt++;
      cmpCnt++;
      if (bus.state !== 3'd0 || bus.instrCnt !== 32'(expCnt)) begin
         failCnt++; $display("[TB] FAIL sw_done: got st=%0d cnt=%0d expected 0/%0d", bus.state, bus.instrCnt, expCnt);
      end
   endtask

   task automatic test_beq;
      for (int z = 1; z >= 0; z--) begin
         bus.opcode = 6'h04; bus.zero = z[0];
         tick(); tick();
         cmpCnt++;
         if (bus.state !== 3'd2 || bus.pcWe !== z[0] || bus.npcSel !== 2'b01 || bus.aluOp !== 3'b001 ||
             bus.bSel !== 1'b0 || bus.retire !== 1'b1 || bus.rfWe !== 1'b0) begin
            failCnt++; $display("[TB] FAIL beq_exec[z=%0d]: got st=%0d pc=%b npc=%b alu=%b b=%b ret=%b rf=%b",
                                z, bus.state, bus.pcWe, bus.npcSel, bus.aluOp, bus.bSel, bus.retire, bus.rfWe);
         end
         tick();
         expCnt++;
         cmpCnt++;
         if (bus.state !== 3'd0 || bus.instrCnt !== 32'(expCnt)) begin
            failCnt++; $display("[TB] FAIL beq_done[z=%0d]: got st=%0d cnt=%0d expected 0/%0d", z, bus.state, bus.instrCnt, expCnt);
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jump;
      bus.opcode = 6'h03; bus.funct = 6'h00;
      tick(); tick();
      cmpCnt++;
      if (bus.state !== 3'd2 || bus.rfWe !== 1'b1 || bus.wrSel !== 2'b10 || bus.wdSel !== 2'b10 ||
          bus.pcWe !== 1'b1 || bus.npcSel !== 2'b10 || bus.retire !== 1'b1) begin
         failCnt++; $display("[TB] FAIL jal_exec: got st=%0d rf=%b wr=%b wd=%b pc=%b npc=%b ret=%b",
                             bus.state, bus.rfWe, bus.wrSel, bus.wdSel, bus.pcWe, bus.npcSel, bus.retire);
      end
      tick();
      expCnt++;
      bus.opcode = 6'h00; bus.funct = 6'h08;
      tick(); tick();
      cmpCnt++;
      if (bus.state !== 3'd2 || bus.npcSel !== 2'b11 || bus.pcWe !== 1'b1 || bus.retire !== 1'b1 || bus.rfWe !== 1'b0) begin
         failCnt++; $display("[TB] FAIL jr_exec: got st=%0d npc=%b pc=%b ret=%b rf=%b",
                             bus.state, bus.npcSel, bus.pcWe, bus.retire, bus.rfWe);
      end
      tick();
      expCnt++;
      cmpCnt++;
      if (bus.state !== 3'd0 || bus.instrCnt !== 32'(expCnt)) begin
         failCnt++; $display("[TB] FAIL jump_done: got st=%0d cnt=%0d expected 0/%0d", bus.state, bus.instrCnt, expCnt);
      end
   endtask

   task automatic test_illegal;
      logic [5:0] ops [2] = '{6'h3f, 6'h00};
      for (int k = 0; k < 2; k++) begin
         bus.opcode = ops[k]; bus.funct = 6'h00;
         for (int i = 0; i < 2; i++) begin
            #1;
            cmpCnt++;
            if (bus.state !== 3'(i) || bus.retire !== (i == 1) || bus.rfWe !== 1'b0 || bus.dmReq !== 1'b0) begin
               failCnt++; $display("[TB] FAIL illegal[%0d][%0d]: got st=%0d ret=%b rf=%b req=%b",
                                   k, i, bus.state, bus.retire, bus.rfWe, bus.dmReq);
            end
            tick();
         end
         expCnt++;
         cmpCnt++;
         if (bus.state !== 3'd0 || bus.instrCnt !== 32'(expCnt)) begin
            failCnt++; $display("[TB] FAIL illegal_done[%0d]: got st=%0d cnt=%0d expected 0/%0d", k, bus.state, bus.instrCnt, expCnt);
         end
      end
   endtask

   task automatic test_timeout;
      int memCycles = 0;
      bus.opcode = 6'h2b; bus.dmReady = 1'b0;
      for (int i = 0; i < 19; i++) begin
         #1;
         if (bus.state === 3'd3 && bus.dmReq === 1'b1) memCycles++;
         if (bus.retire !== 1'b0) begin
            cmpCnt++; failCnt++;
            $display("[TB] FAIL timeout_retire[%0d]: got 1 expected 0", i);
         end
         tick();
      end
      cmpCnt++;
      if (memCycles !== 16) begin failCnt++; $display("[TB] FAIL timeout_mem_cycles: got %0d expected 16", memCycles); end
      cmpCnt++;
      if (bus.state !== 3'd0 || bus.busErr !== 1'b1 || bus.instrCnt !== 32'(expCnt)) begin
         failCnt++; $display("[TB] FAIL timeout_done: got st=%0d err=%b cnt=%0d expected 0/1/%0d",
                             bus.state, bus.busErr, bus.instrCnt, expCnt);
      end
      // A following nop must still retire while the error stays sticky
      bus.opcode = 6'h00; bus.funct = 6'h00;
      tick(); tick();
      expCnt++;
      cmpCnt++;
      if (bus.busErr !== 1'b1 || bus.instrCnt !== 32'(expCnt)) begin
         failCnt++; $display("[TB] FAIL timeout_sticky: got err=%b cnt=%0d expected 1/%0d", bus.busErr, bus.instrCnt, expCnt);
      end
   endtask

   task automatic test_reset_mid_mem;
      bus.opcode = 6'h23; bus.dmReady = 1'b0;
      tick(); tick(); tick();
      cmpCnt++;
      if (bus.state !== 3'd3 || bus.dmReq !== 1'b1) begin
         failCnt++; $display("[TB] FAIL midreset_pre: got st=%0d req=%b expected 3/1", bus.state, bus.dmReq);
      end
      #1 reset = 1'b1;
      #1;
      cmpCnt++;
      if (bus.state !== 3'd0 || {bus.pcWe, bus.irWe, bus.rfWe, bus.dmReq, bus.dmWe, bus.retire} !== 6'b0 ||
          bus.instrCnt !== 32'd0 || bus.busErr !== 1'b0) begin
         failCnt++; $display("[TB] FAIL midreset: got st=%0d en=%b cnt=%0d err=%b expected 0/0/0/0", bus.state,
                             {bus.pcWe, bus.irWe, bus.rfWe, bus.dmReq, bus.dmWe, bus.retire}, bus.instrCnt, bus.busErr);
      end
      tick();
      reset = 1'b0;
   endtask

   // Absolute time limit so a stuck run still reports
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      $display("[TB] starting mc_ctrl bench");
      test_reset();
      test_addu();
      test_imm();
      test_lw();
      test_sw();
      test_beq();
      test_jump();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
      $finish;
   end

endmodule
